apb4_master: RTL and testbench
==============================

APB4_MASTER -- requirements
Module: apb4_master

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 32, PADDR width.
REQ-002 SHALL have parameters: DATA_WIDTH, 32, PWDATA/PRDATA width (8, 16 or 32).
REQ-003 SHALL have parameters: TIMEOUT, 16, max ACCESS cycles without PREADY (0 disables timeout).
REQ-004 SHALL have ports (clock and reset first):
- PCLK  in  1  single clock; all logic rising-edge.
- PRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response accept.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts).
- rsp_err  out  1  PSLVERR or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL, PENABLE, PWRITE  out  1 each  APB4 control.
- PADDR  out  ADDR_WIDTH;  PWDATA  out  DATA_WIDTH;  PSTRB  out  DATA_WIDTH/8;  PPROT  out  3.
- PRDATA  in  DATA_WIDTH;  PREADY  in  1;  PSLVERR  in  1.

Function
REQ-005 SHALL implement FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; no other states.
REQ-006 cmd_ready SHALL be 1 only in IDLE with PRESETn high; a command SHALL be accepted on a rising edge with cmd_valid && cmd_ready.
REQ-007 On accept, SHALL latch cmd_* into PADDR/PWRITE/PWDATA/PSTRB/PPROT and enter SETUP.
REQ-008 SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then unconditionally ACCESS.
REQ-009 ACCESS: PSEL=1, PENABLE=1; PADDR, PWRITE, PWDATA, PSTRB, PPROT SHALL stay stable from SETUP until the transfer ends.
REQ-010 Reads SHALL drive PSTRB=0 and PWDATA=0.
REQ-011 ACCESS with PREADY=1 SHALL end the transfer at that edge, with:
- PSEL=PENABLE=0 next cycle.
- rsp_rdata=PRDATA (reads) or 0 (writes).
- rsp_err=PSLVERR; rsp_timeout=0.
- State RESP.
REQ-012 SHALL count ACCESS cycles with PREADY=0; when TIMEOUT!=0 and the count reaches TIMEOUT, SHALL abort:
- PSEL=PENABLE=0.
- rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- State RESP.
- A later PREADY is ignored.
REQ-013 The timeout counter SHALL be ceil(log2(TIMEOUT+1)) bits, cleared on SETUP entry, and SHALL never wrap.
REQ-014 RESP: rsp_valid=1 with rsp_rdata/rsp_err/rsp_timeout held constant until rsp_valid && rsp_ready, then IDLE; APB outputs idle (PSEL=PENABLE=0).
REQ-015 Minimum latency, zero-wait slave: accept at edge N, SETUP cycle N..N+1, ACCESS N+1..N+2, rsp_valid=1 after edge N+2; next accept no earlier than the edge after response handshake.
REQ-016 A single outstanding transfer only; cmd_valid during SETUP/ACCESS/RESP SHALL be ignored (cmd_ready=0).
REQ-017 PSLVERR SHALL be sampled only in ACCESS with PREADY=1; PRDATA outside that cycle SHALL be ignored.

Reset
REQ-018 PRESETn low SHALL asynchronously force:
- State IDLE; counter 0.
- PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT = 0.
- rsp_valid, rsp_rdata, rsp_err, rsp_timeout = 0.
- cmd_ready = 0.
REQ-019 Reset during SETUP/ACCESS/RESP SHALL discard the transfer with no response; first accept possible on the first edge after PRESETn rises.

Verification
REQ-020 Write, zero-wait: addr 0x10, wdata 0xA5A5_A5A5, strb 0xF, PREADY=1 -> one SETUP, one ACCESS cycle; rsp_valid next cycle, rsp_err=0, rsp_rdata=0.
REQ-021 Read, 3 wait states: addr 0x20, slave returns 0xDEAD_BEEF on 4th ACCESS cycle -> PADDR stable for 5 cycles, PSTRB=0, rsp_rdata=0xDEAD_BEEF.
REQ-022 Slave error: read with PREADY=1, PSLVERR=1 -> rsp_err=1, rsp_timeout=0.
REQ-023 Timeout with TIMEOUT=16, PREADY held 0 -> abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-024 Backpressure: rsp_ready=0 for 5 cycles -> rsp fields stable, cmd_ready=0, PSEL=0 throughout.
REQ-025 Reset in ACCESS: PRESETn low mid-ACCESS -> PSEL=PENABLE=0 immediately, no rsp_valid; new command after release completes normally.

Source files
------------

// File: rtl/apb4_master.sv
// APB4 master bridging a valid/ready command/response pair onto a single APB4 bus.
// One transfer in flight at a time; optional ACCESS-phase timeout aborts stalled slaves.
module apb4_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,

    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [2:0]              PPROT,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
    // Count value seen on the last permitted stalled ACCESS cycle.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
    logic [2:0]              pprot_q, pprot_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    pstrb_d  = cmd_write ? cmd_strb : '0;
                    pprot_d  = cmd_prot;
                    cnt_d    = '0;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (PREADY) begin
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    state_d       = StResp;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = StResp;
                end else if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                    // Saturate rather than wrap when the timeout is disabled.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // PRESETn gates cmd_ready so nothing is offered while reset is asserted.
    assign cmd_ready   = (state_q == StIdle) && PRESETn;
    assign PSEL        = (state_q == StSetup) || (state_q == StAccess);
    assign PENABLE     = (state_q == StAccess);
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign PPROT       = pprot_q;
    assign rsp_valid   = (state_q == StResp);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb4_master.sv
// Scoreboard bench for apb4_master: randomized commands, a scripted APB slave and a
// response monitor checked against a transaction-level reference model.
module tb_apb4_master;

    localparam int TO = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PREADY, PSLVERR;

    always #5 PCLK = ~PCLK;

    apb4_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .cmd_prot   (cmd_prot),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PSTRB      (PSTRB),
        .PPROT      (PPROT),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;   // ACCESS cycles with PREADY=0 before the slave answers
        logic [31:0] rdata;
        logic        slverr;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } rsp_t;

    txn_t apb_q[$];
    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   bp_hold = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [2:0] p, input int wt,
                                input logic [31:0] rd, input logic e);
        txn_t t;
        t.write = w; t.addr = a; t.wdata = d; t.strb = s; t.prot = p;
        t.waits = wt; t.rdata = rd; t.slverr = e;
        return t;
    endfunction

    // Reference model: a slave that stalls for TO cycles or more is aborted.
    function automatic bit times_out(input txn_t t);
        return (TO != 0) && (t.waits >= TO);
    endfunction

    function automatic rsp_t model(input txn_t t);
        rsp_t r;
        if (times_out(t)) begin
            r.rdata = 32'h0; r.err = 1'b1; r.timeout = 1'b1;
        end else begin
            r.rdata = t.write ? 32'h0 : t.rdata; r.err = t.slverr; r.timeout = 1'b0;
        end
        return r;
    endfunction

    function automatic int access_cycles(input txn_t t);
        return times_out(t) ? TO : t.waits + 1;
    endfunction

    function automatic logic [127:0] bus_exp(input txn_t t);
        return {56'h0, t.addr, t.write, (t.write ? t.wdata : 32'h0),
                (t.write ? t.strb : 4'h0), t.prot};
    endfunction

    task automatic issue(input txn_t t);
        bit done;
        done = 1'b0;
        apb_q.push_back(t);
        exp_q.push_back(model(t));
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = t.write; cmd_addr = t.addr;
        cmd_wdata = t.wdata; cmd_strb = t.strb; cmd_prot = t.prot;
        for (int i = 0; i < 200 && !done; i++) begin
            if (cmd_ready) done = 1'b1;
            @(negedge PCLK);
        end
        cmd_valid = 1'b0;
        cmd_wdata = $urandom;
        chk("cmd_accept", {127'h0, done}, 128'h1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600 && !(exp_q.size() == 0 && cmd_ready); i++) @(negedge PCLK);
        chk("drain", exp_q.size(), 0);
    endtask

    // Scripted APB slave plus bus protocol checks.
    initial begin
        txn_t cur;
        int   acc;
        bit   active;
        acc = 0; active = 1'b0;
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                active = 1'b0;
                PREADY = 1'b0;
            end else if (PSEL && !PENABLE) begin
                if (apb_q.size() == 0) begin
                    chk("setup_unexpected", apb_q.size(), 1);
                end else begin
                    cur = apb_q.pop_front();
                    active = 1'b1;
                    acc = 0;
                    chk("setup_bus", {PADDR, PWRITE, PWDATA, PSTRB, PPROT}, bus_exp(cur));
                end
                PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
            end else if (PSEL && PENABLE) begin
                acc++;
                if (active) begin
                    chk("access_bus", {PADDR, PWRITE, PWDATA, PSTRB, PPROT}, bus_exp(cur));
                end
                if (active && acc == cur.waits + 1) begin
                    PREADY = 1'b1; PRDATA = cur.rdata; PSLVERR = cur.slverr;
                end else begin
                    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
                end
            end else begin
                if (active) begin
                    chk("access_cycles", acc, access_cycles(cur));
                    chk("rsp_latency", {127'h0, rsp_valid}, 128'h1);
                    active = 1'b0;
                end
                PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
            end
        end
    end

    // Response monitor / scoreboard.
    initial begin
        rsp_t         e;
        logic [127:0] held;
        bit           have;
        have = 1'b0; held = '0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                have = 1'b0;
                rsp_ready = 1'b0;
            end else if (rsp_valid) begin
                if (!have) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", rsp_err, e.err);
                        chk("rsp_timeout", rsp_timeout, e.timeout);
                    end
                    held = {94'h0, rsp_rdata, rsp_err, rsp_timeout};
                    have = 1'b1;
                end else begin
                    chk("rsp_stable", {94'h0, rsp_rdata, rsp_err, rsp_timeout}, held);
                end
                chk("rsp_bus_idle", {PSEL, PENABLE, cmd_ready}, 0);
                if (bp_hold > 0) begin
                    bp_hold--;
                    rsp_ready = 1'b0;
                end else begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                if (rsp_ready) have = 1'b0;
            end else begin
                rsp_ready = 1'($urandom);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        txn_t t;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
        #13;
        chk("reset_outputs", {cmd_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
                              rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, 0);
        @(negedge PCLK);
        #2 PRESETn = 1'b1;
        @(negedge PCLK);
        chk("ready_after_reset", {127'h0, cmd_ready}, 128'h1);

        issue(mk(1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, 3'b000, 0, 32'h0, 1'b0));
        issue(mk(1'b0, 32'h20, 32'h1234_5678, 4'hF, 3'b010, 3, 32'hDEAD_BEEF, 1'b0));
        issue(mk(1'b0, 32'h24, 32'h0, 4'h0, 3'b001, 0, 32'h5555_0055, 1'b1));
        issue(mk(1'b0, 32'h28, 32'h0, 4'h0, 3'b000, 30, 32'hCAFE_F00D, 1'b0));
        issue(mk(1'b1, 32'h2C, 32'h0BAD_CAFE, 4'h5, 3'b111, TO - 1, 32'h0, 1'b0));
        issue(mk(1'b0, 32'h30, 32'h0, 4'h0, 3'b100, TO, 32'h1111_2222, 1'b0));

        // Response backpressure.
        wait_idle();
        bp_hold = 5;
        issue(mk(1'b1, 32'h40, 32'h0F0F_0F0F, 4'h3, 3'b011, 1, 32'h0, 1'b1));

        // Reset asserted mid-ACCESS discards the transfer.
        wait_idle();
        issue(mk(1'b0, 32'h50, 32'h0, 4'h0, 3'b000, 10, 32'h7777_7777, 1'b0));
        repeat (3) @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1 chk("reset_mid_access", {PSEL, PENABLE, rsp_valid, cmd_ready}, 0);
        exp_q.delete();
        apb_q.delete();
        repeat (2) @(negedge PCLK);
        chk("reset_held", {PSEL, PENABLE, rsp_valid, cmd_ready, PADDR}, 0);
        #2 PRESETn = 1'b1;
        issue(mk(1'b0, 32'h54, 32'h0, 4'h0, 3'b010, 2, 32'h8888_9999, 1'b0));

        for (int n = 0; n < 40; n++) begin
            t = mk(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
                   ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 2)
                                               : $urandom_range(0, 3),
                   $urandom, ($urandom_range(0, 4) == 0));
            issue(t);
        end
        wait_idle();
        repeat (3) @(negedge PCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
